// File: rtl/pes_wm_plant_if.sv
// Actuator/sensor bundle between the washing-machine controller and its plant emulator.
// The controller takes the master modport and the plant takes the slave modport.
interface pes_wm_plant_if #(
    parameter int unsigned LEVEL_W = 8
);
    logic               door_lock;
    logic               motor_on;
    logic               fill_value_on;
    logic               drain_value_on;
    logic               soap_wash;
    logic               water_wash;
    logic               done;
    logic               filled;
    logic               detergent_added;
    logic               cycle_timeout;
    logic               drained;
    logic               spin_timeout;
    logic [LEVEL_W-1:0] water_level;
    logic               fault;

    modport master (
        output door_lock, motor_on, fill_value_on, drain_value_on,
               soap_wash, water_wash, done,
        input  filled, detergent_added, cycle_timeout, drained,
               spin_timeout, water_level, fault
    );

    modport slave (
        input  door_lock, motor_on, fill_value_on, drain_value_on,
               soap_wash, water_wash, done,
        output filled, detergent_added, cycle_timeout, drained,
               spin_timeout, water_level, fault
    );
endinterface

// File: rtl/pes_wm_plant.sv
// Washing-machine plant emulator: water level, detergent dispenser, wash/spin timers
// and a sticky fault flag, all registered so the controller loop closes in one cycle.
module pes_wm_plant #(
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned LEVEL_FULL  = 200,
    parameter int unsigned FILL_RATE   = 10,
    parameter int unsigned DRAIN_RATE  = 20,
    parameter int unsigned DET_CYCLES  = 4,
    parameter int unsigned WASH_CYCLES = 16,
    parameter int unsigned SPIN_CYCLES = 12,
    parameter int unsigned TMR_W       = 8
) (
    input logic           clk,
    input logic           reset,
    pes_wm_plant_if.slave plant
);
    localparam logic [LEVEL_W:0] FULL_X  = (LEVEL_W+1)'(LEVEL_FULL);
    localparam logic [LEVEL_W:0] FILL_X  = (LEVEL_W+1)'(FILL_RATE);
    localparam logic [LEVEL_W:0] DRAIN_X = (LEVEL_W+1)'(DRAIN_RATE);
    localparam logic [TMR_W-1:0] DET_T   = TMR_W'(DET_CYCLES);
    localparam logic [TMR_W-1:0] WASH_T  = TMR_W'(WASH_CYCLES);
    localparam logic [TMR_W-1:0] SPIN_T  = TMR_W'(SPIN_CYCLES);

    logic [LEVEL_W-1:0] level_q, level_nxt;
    logic [TMR_W-1:0]   det_q, det_nxt;
    logic [TMR_W-1:0]   wash_q, wash_nxt;
    logic [TMR_W-1:0]   spin_q, spin_nxt;
    logic [1:0]         phase_q;
    logic               filled_q, drained_q;
    logic               det_flag_q, det_flag_nxt;
    logic               wash_flag_q, wash_flag_nxt;
    logic               spin_flag_q, spin_flag_nxt;
    logic               fault_q, fault_nxt;

    logic [LEVEL_W:0]   level_x;
    logic [LEVEL_W:0]   fill_sum;
    logic [1:0]         phase;
    logic               det_clr, wash_clr, spin_clr;
    logic               det_run, wash_run, spin_run;

    always_comb begin
        level_x   = {1'b0, level_q};
        fill_sum  = level_x + FILL_X;
        level_nxt = level_q;
        if (plant.fill_value_on && !plant.drain_value_on) begin
            level_nxt = (fill_sum >= FULL_X) ? FULL_X[LEVEL_W-1:0] : fill_sum[LEVEL_W-1:0];
        end else if (plant.drain_value_on && !plant.fill_value_on) begin
            level_nxt = (level_x >= DRAIN_X) ? level_q - DRAIN_X[LEVEL_W-1:0] : '0;
        end
    end

    always_comb begin
        phase = {plant.soap_wash, plant.water_wash};

        det_clr  = plant.done || !plant.door_lock;
        det_run  = plant.door_lock && plant.soap_wash && filled_q;
        det_nxt  = det_q;
        if (det_clr)
            det_nxt = '0;
        else if (det_run && det_q < DET_T)
            det_nxt = det_q + 1'b1;
        det_flag_nxt = !det_clr && (det_flag_q || det_nxt == DET_T);

        // Clearing (motor off, door open, phase change) beats counting on the same edge.
        wash_clr = !plant.motor_on || !plant.door_lock || (phase != phase_q);
        wash_run = plant.motor_on && !plant.drain_value_on && filled_q &&
                   (plant.soap_wash ^ plant.water_wash);
        wash_nxt = wash_q;
        if (wash_clr)
            wash_nxt = '0;
        else if (wash_run && wash_q < WASH_T)
            wash_nxt = wash_q + 1'b1;
        wash_flag_nxt = !wash_clr && (wash_nxt == WASH_T);

        spin_clr = !plant.motor_on || !plant.door_lock;
        spin_run = plant.motor_on && plant.drain_value_on;
        spin_nxt = spin_q;
        if (spin_clr)
            spin_nxt = '0;
        else if (spin_run && spin_q < SPIN_T)
            spin_nxt = spin_q + 1'b1;
        spin_flag_nxt = !spin_clr && (spin_nxt == SPIN_T);

        fault_nxt = fault_q ||
                    (plant.fill_value_on && plant.drain_value_on) ||
                    (!plant.door_lock && level_q != '0) ||
                    (plant.motor_on && !plant.door_lock);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= '0;
            det_q       <= '0;
            wash_q      <= '0;
            spin_q      <= '0;
            phase_q     <= '0;
            filled_q    <= 1'b0;
            drained_q   <= 1'b1;
            det_flag_q  <= 1'b0;
            wash_flag_q <= 1'b0;
            spin_flag_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            level_q     <= level_nxt;
            det_q       <= det_nxt;
            wash_q      <= wash_nxt;
            spin_q      <= spin_nxt;
            phase_q     <= phase;
            filled_q    <= (level_nxt == FULL_X[LEVEL_W-1:0]);
            drained_q   <= (level_nxt == '0);
            det_flag_q  <= det_flag_nxt;
            wash_flag_q <= wash_flag_nxt;
            spin_flag_q <= spin_flag_nxt;
            fault_q     <= fault_nxt;
        end
    end

    assign plant.water_level     = level_q;
    assign plant.filled          = filled_q;
    assign plant.drained         = drained_q;
    assign plant.detergent_added = det_flag_q;
    assign plant.cycle_timeout   = wash_flag_q;
    assign plant.spin_timeout    = spin_flag_q;
    assign plant.fault           = fault_q;
endmodule

// File: tb/tb_pes_wm_plant.sv
// Directed bench for pes_wm_plant: fill, detergent, wash/spin timers, faults, async reset.
module tb_pes_wm_plant;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    pes_wm_plant_if #(.LEVEL_W(8)) bus ();

    pes_wm_plant #(
        .LEVEL_W(8), .LEVEL_FULL(200), .FILL_RATE(10), .DRAIN_RATE(20),
        .DET_CYCLES(4), .WASH_CYCLES(16), .SPIN_CYCLES(12), .TMR_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .plant (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.door_lock = 0; bus.motor_on = 0; bus.fill_value_on = 0;
        bus.drain_value_on = 0; bus.soap_wash = 0; bus.water_wash = 0; bus.done = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        total++; if (bus.water_level !== 8'd0) $display("FAIL %s level got %0d want 0", tag, bus.water_level); else passed++;
        total++; if (bus.filled !== 1'b0) $display("FAIL %s filled got %b want 0", tag, bus.filled); else passed++;
        total++; if (bus.drained !== 1'b1) $display("FAIL %s drained got %b want 1", tag, bus.drained); else passed++;
        total++; if (bus.detergent_added !== 1'b0) $display("FAIL %s det got %b want 0", tag, bus.detergent_added); else passed++;
        total++; if (bus.cycle_timeout !== 1'b0) $display("FAIL %s cycle_to got %b want 0", tag, bus.cycle_timeout); else passed++;
        total++; if (bus.spin_timeout !== 1'b0) $display("FAIL %s spin_to got %b want 0", tag, bus.spin_timeout); else passed++;
        total++; if (bus.fault !== 1'b0) $display("FAIL %s fault got %b want 0", tag, bus.fault); else passed++;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
    endtask

    task automatic test_fill();
        bus.door_lock = 1; bus.fill_value_on = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total++; if (bus.water_level !== 8'(i*10)) $display("FAIL fill_level[%0d] got %0d want %0d", i, bus.water_level, i*10); else passed++;
            total++; if (bus.filled !== (i == 20)) $display("FAIL fill_filled[%0d] got %b want %b", i, bus.filled, (i == 20)); else passed++;
            total++; if (bus.drained !== 1'b0) $display("FAIL fill_drained[%0d] got %b want 0", i, bus.drained); else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.water_level !== 8'd200) $display("FAIL fill_sat[%0d] got %0d want 200", i, bus.water_level); else passed++;
            total++; if (bus.filled !== 1'b1) $display("FAIL fill_sat_filled[%0d] got %b want 1", i, bus.filled); else passed++;
        end
        bus.fill_value_on = 0;
    endtask

    task automatic test_detergent();
        bus.soap_wash = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (bus.detergent_added !== (i == 4)) $display("FAIL det[%0d] got %b want %b", i, bus.detergent_added, (i == 4)); else passed++;
        end
        bus.soap_wash = 0;
        tick();
        total++; if (bus.detergent_added !== 1'b1) $display("FAIL det_hold got %b want 1", bus.detergent_added); else passed++;
        bus.done = 1;
        tick();
        total++; if (bus.detergent_added !== 1'b0) $display("FAIL det_done_clr got %b want 0", bus.detergent_added); else passed++;
        total++; if (bus.water_level !== 8'd200) $display("FAIL done_level got %0d want 200", bus.water_level); else passed++;
        bus.done = 0;
    endtask

    task automatic test_wash();
        bus.soap_wash = 1;
        tick();
        bus.motor_on = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++; if (bus.cycle_timeout !== (i == 16)) $display("FAIL wash_soap[%0d] got %b want %b", i, bus.cycle_timeout, (i == 16)); else passed++;
        end
        repeat (2) begin
            tick();
            total++; if (bus.cycle_timeout !== 1'b1) $display("FAIL wash_hold got %b want 1", bus.cycle_timeout); else passed++;
        end
        bus.soap_wash = 0; bus.water_wash = 1;
        tick();
        total++; if (bus.cycle_timeout !== 1'b0) $display("FAIL wash_phase_clr got %b want 0", bus.cycle_timeout); else passed++;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++; if (bus.cycle_timeout !== (i == 16)) $display("FAIL wash_rinse[%0d] got %b want %b", i, bus.cycle_timeout, (i == 16)); else passed++;
        end
        bus.motor_on = 0;
        tick();
        total++; if (bus.cycle_timeout !== 1'b0) $display("FAIL wash_motor_clr got %b want 0", bus.cycle_timeout); else passed++;
        bus.water_wash = 0;
    endtask

    task automatic test_spin();
        int exp_lvl;
        bus.drain_value_on = 1; bus.motor_on = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_lvl = (200 - 20*i < 0) ? 0 : 200 - 20*i;
            total++; if (bus.water_level !== 8'(exp_lvl)) $display("FAIL spin_level[%0d] got %0d want %0d", i, bus.water_level, exp_lvl); else passed++;
            total++; if (bus.drained !== (i >= 10)) $display("FAIL spin_drained[%0d] got %b want %b", i, bus.drained, (i >= 10)); else passed++;
            total++; if (bus.spin_timeout !== (i == 12)) $display("FAIL spin_to[%0d] got %b want %b", i, bus.spin_timeout, (i == 12)); else passed++;
        end
        bus.motor_on = 0;
        tick();
        total++; if (bus.spin_timeout !== 1'b0) $display("FAIL spin_motor_clr got %b want 0", bus.spin_timeout); else passed++;
        total++; if (bus.fault !== 1'b0) $display("FAIL spin_fault got %b want 0", bus.fault); else passed++;
        bus.drain_value_on = 0;
    endtask

    task automatic test_fault();
        bus.fill_value_on = 1;
        repeat (10) tick();
        total++; if (bus.water_level !== 8'd100) $display("FAIL fault_pre_level got %0d want 100", bus.water_level); else passed++;
        bus.drain_value_on = 1;
        tick();
        total++; if (bus.water_level !== 8'd100) $display("FAIL both_valves_level got %0d want 100", bus.water_level); else passed++;
        total++; if (bus.fault !== 1'b1) $display("FAIL both_valves_fault got %b want 1", bus.fault); else passed++;
        bus.fill_value_on = 0; bus.drain_value_on = 0;
        repeat (3) tick();
        total++; if (bus.fault !== 1'b1) $display("FAIL fault_sticky got %b want 1", bus.fault); else passed++;

        do_reset();
        bus.door_lock = 1; bus.fill_value_on = 1;
        repeat (10) tick();
        bus.fill_value_on = 0;
        total++; if (bus.fault !== 1'b0) $display("FAIL fault_after_reset got %b want 0", bus.fault); else passed++;
        bus.door_lock = 0;
        tick();
        total++; if (bus.fault !== 1'b1) $display("FAIL door_open_wet got %b want 1", bus.fault); else passed++;
        total++; if (bus.water_level !== 8'd100) $display("FAIL door_open_level got %0d want 100", bus.water_level); else passed++;
        bus.door_lock = 1;
        repeat (4) tick();
        total++; if (bus.fault !== 1'b1) $display("FAIL door_fault_sticky got %b want 1", bus.fault); else passed++;

        // motor with door open faults even on an empty tub
        do_reset();
        bus.door_lock = 0; bus.motor_on = 1;
        tick();
        total++; if (bus.fault !== 1'b1) $display("FAIL motor_unlocked got %b want 1", bus.fault); else passed++;
        bus.motor_on = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.door_lock = 1; bus.fill_value_on = 1;
        repeat (20) tick();
        bus.fill_value_on = 0; bus.soap_wash = 1;
        tick();
        bus.motor_on = 1;
        repeat (5) tick();
        total++; if (bus.detergent_added !== 1'b1) $display("FAIL pre_areset_det got %b want 1", bus.detergent_added); else passed++;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("areset");
        tick();
        reset = 1'b0;
        clear_inputs();
        bus.door_lock = 1; bus.fill_value_on = 1;
        tick();
        total++; if (bus.water_level !== 8'd10) $display("FAIL resume_level got %0d want 10", bus.water_level); else passed++;
        total++; if (bus.drained !== 1'b0) $display("FAIL resume_drained got %b want 0", bus.drained); else passed++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_detergent();
        test_wash();
        test_spin();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
